// File: rtl/map_port_arbiter_if.sv
// map_port_arbiter_if: video, bot and RAM bundle of the map port arbiter.
// slave = arbiter side, master = scan logic / bot controller / RAM side.
interface map_port_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              vid_active;
  logic [ADDR_W-1:0] vid_addr;
  logic [1:0]        vid_world;
  logic              vid_en_out;
  logic              vid_stolen;
  logic              bot_req;
  logic [ADDR_W-1:0] bot_addr;
  logic              bot_ack;
  logic [1:0]        bot_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_dout;
  logic [15:0]       steal_count;

  modport slave (
    input  vid_active,
    input  vid_addr,
    input  bot_req,
    input  bot_addr,
    input  ram_dout,
    output vid_world,
    output vid_en_out,
    output vid_stolen,
    output bot_ack,
    output bot_data,
    output ram_addr,
    output steal_count
  );

  modport master (
    output vid_active,
    output vid_addr,
    output bot_req,
    output bot_addr,
    output ram_dout,
    input  vid_world,
    input  vid_en_out,
    input  vid_stolen,
    input  bot_ack,
    input  bot_data,
    input  ram_addr,
    input  steal_count
  );
endinterface

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the single-port world-map RAM between the
// video scan path (priority in active display) and the bot controller.
// Ports: clk, reset_n (async, active low), bus (map_port_arbiter_if.slave:
//   vid_active/vid_addr in, vid_world/vid_en_out/vid_stolen out,
//   bot_req/bot_addr in, bot_ack/bot_data out, ram_addr out, ram_dout in,
//   steal_count out).
// Option: define ARB_STATS_EN to count slots stolen during active video;
//   otherwise steal_count is tied to zero.
module map_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               reset_n,
  map_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_WAIT = 2'd1,
    B_ACK  = 2'd2
  } botSt_t;

  localparam logic [2:0] LAT  = 3'(RAM_LAT);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  botSt_t            state;
  botSt_t            stateNxt;
  logic [2:0]        latCnt;
  logic [2:0]        latNxt;
  logic [7:0]        starveCnt;
  logic [7:0]        starveNxt;
  logic              capture;
  logic              botGrant;
  logic [ADDR_W-1:0] ramAddr;
  logic [1:0]        botData;
  logic [1:0]        vidWorld;
  logic              vidEn;
  logic              vidStolen;

  // Stage 0 rides with ram_addr; stage RAM_LAT lines up with ram_dout.
  logic [RAM_LAT:0]  tagPipe;
  logic [RAM_LAT:0]  actPipe;

  assign botGrant = (state == B_IDLE)
                 && bus.bot_req
                 && (!bus.vid_active || starveCnt == SMAX);

  // Slot owner: address register plus tag / active-flag pipes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramAddr <= '0;
      tagPipe <= '0;
      actPipe <= '0;
    end else begin
      ramAddr <= botGrant ? bus.bot_addr : bus.vid_addr;
      tagPipe <= {tagPipe[RAM_LAT-1:0], botGrant};
      actPipe <= {actPipe[RAM_LAT-1:0], bus.vid_active};
    end
  end

  // Video beat: a bot-owned slot repeats the last word and flags it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vidWorld  <= 2'b00;
      vidEn     <= 1'b0;
      vidStolen <= 1'b0;
    end else begin
      vidEn <= actPipe[RAM_LAT];
      if (tagPipe[RAM_LAT]) begin
        vidStolen <= actPipe[RAM_LAT];
      end else begin
        vidWorld  <= bus.ram_dout;
        vidStolen <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= B_IDLE;
      latCnt    <= '0;
      starveCnt <= '0;
      botData   <= 2'b00;
    end else begin
      state     <= stateNxt;
      latCnt    <= latNxt;
      starveCnt <= starveNxt;
      if (capture) begin
        botData <= bus.ram_dout;
      end
    end
  end

  // Bot read FSM: the latency counter runs RAM_LAT..0 so the capture
  // lands on the edge where ram_dout carries the granted address.
  always_comb begin
    stateNxt = state;
    latNxt   = latCnt;
    capture  = 1'b0;
    unique case (state)
      B_IDLE: begin
        if (botGrant) begin
          stateNxt = B_WAIT;
          latNxt   = LAT;
        end
      end
      B_WAIT: begin
        if (latCnt == 3'd0) begin
          capture  = 1'b1;
          stateNxt = B_ACK;
        end else begin
          latNxt = latCnt - 3'd1;
        end
      end
      B_ACK: begin
        stateNxt = B_IDLE;
      end
      default: begin
        stateNxt = B_IDLE;
      end
    endcase
  end

  // Starvation: counts only while the bot is actually blocked by video.
  always_comb begin
    starveNxt = starveCnt;
    if (botGrant || !bus.bot_req) begin
      starveNxt = 8'd0;
    end else if (state == B_IDLE
              && bus.vid_active
              && starveCnt != SMAX) begin
      starveNxt = starveCnt + 8'd1;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stealCnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stealCnt <= 16'h0000;
    end else if (botGrant
              && bus.vid_active
              && stealCnt != 16'hFFFF) begin
      stealCnt <= stealCnt + 16'h0001;
    end
  end

  assign bus.steal_count = stealCnt;
`else
  assign bus.steal_count = 16'h0000;
`endif

  assign bus.ram_addr   = ramAddr;
  assign bus.vid_world  = vidWorld;
  assign bus.vid_en_out = vidEn;
  assign bus.vid_stolen = vidStolen;
  assign bus.bot_ack    = (state == B_ACK);
  assign bus.bot_data   = botData;

endmodule
